updn_counter: RTL and testbench

UPDN_COUNTER -- requirements
Module: updn_counter

---
 rtl/updn_counter.sv | 91 +++++++++
 tb/tb_updn_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/updn_counter.sv
// Up/down counter with parallel load, limit-crossing pulse and sticky ovf/unf flags.
// Define UPDN_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module updn_counter #(
  parameter int unsigned          WIDTH = 4,
  parameter logic [WIDTH-1:0]     MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dnb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             ovf,
  output logic             unf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

`ifdef UPDN_COUNTER_SAT_EN
  localparam logic [WIDTH-1:0] UP_LIMIT_NEXT = MAX;
  localparam logic [WIDTH-1:0] DN_LIMIT_NEXT = ZERO;
`else
  localparam logic [WIDTH-1:0] UP_LIMIT_NEXT = ZERO;
  localparam logic [WIDTH-1:0] DN_LIMIT_NEXT = MAX;
`endif

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             up_limit, dn_limit;

  assign up_limit = (count_q == MAX);
  assign dn_limit = (count_q == ZERO);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q & ~clr_flags;
    unf_d   = unf_q & ~clr_flags;
    if (load) begin
      count_d = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (up_dnb) begin
        if (up_limit) begin
          count_d = UP_LIMIT_NEXT;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (dn_limit) begin
          count_d = DN_LIMIT_NEXT;
          wrap_d  = 1'b1;
          unf_d   = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= ZERO;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign at_max = up_limit;
  assign at_min = dn_limit;

endmodule

// File: tb/tb_updn_counter.sv
// Bench for updn_counter: directed scenarios plus random traffic against an arithmetic model.
module tb_updn_counter;

  localparam int M = 9;
`ifdef UPDN_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up_dnb, load, clr_flags;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       wrap, ovf, unf, at_max, at_min;

  logic       rst8, en8, up8, load8, clr8;
  logic [7:0] load_val8;
  logic [7:0] count8;
  logic       wrap8, ovf8, unf8, at_max8, at_min8;

  updn_counter #(.WIDTH(4), .MAX(4'd9)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dnb(up_dnb), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(count),
    .wrap(wrap), .ovf(ovf), .unf(unf), .at_max(at_max), .at_min(at_min)
  );

  updn_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .up_dnb(up8), .load(load8),
    .load_val(load_val8), .clr_flags(clr8), .count(count8),
    .wrap(wrap8), .ovf(ovf8), .unf(unf8), .at_max(at_max8), .at_min(at_min8)
  );

  int tests = 0;
  int fails = 0;

  int m_count = 0;
  bit m_wrap = 0, m_ovf = 0, m_unf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count lives on a ring of MAX+1 values; a limit event is a step off either end.
  task automatic model_edge();
    bit lim_up, lim_dn;
    int nc;
    lim_up = 0;
    lim_dn = 0;
    if (rst) begin
      m_count = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
    end else begin
      nc = m_count;
      if (load) begin
        nc = (int'(load_val) > M) ? M : int'(load_val);
      end else if (en && up_dnb) begin
        lim_up = (m_count == M);
        nc = (SAT && lim_up) ? M : (m_count + 1) % (M + 1);
      end else if (en) begin
        lim_dn = (m_count == 0);
        nc = (SAT && lim_dn) ? 0 : (m_count + M) % (M + 1);
      end
      m_wrap  = lim_up || lim_dn;
      m_ovf   = (m_ovf && !clr_flags) || lim_up;
      m_unf   = (m_unf && !clr_flags) || lim_dn;
      m_count = nc;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},  32'(count),  32'(m_count));
    chk({tag, ".wrap"},   32'(wrap),   32'(m_wrap));
    chk({tag, ".ovf"},    32'(ovf),    32'(m_ovf));
    chk({tag, ".unf"},    32'(unf),    32'(m_unf));
    chk({tag, ".at_max"}, 32'(at_max), 32'(m_count == M));
    chk({tag, ".at_min"}, 32'(at_min), 32'(m_count == 0));
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lv, input logic c);
    rst = r; en = e; up_dnb = u; load = l; load_val = lv; clr_flags = c;
  endtask

  int pulses;

  initial begin
    rst8 = 1'b1; en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; clr8 = 1'b0; load_val8 = 8'd0;
    drive(1, 0, 0, 0, 4'd0, 0);
    #1;
    cyc("reset");

    // 12 up steps from 0
    drive(0, 1, 1, 0, 4'd0, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc("up12");
      if (wrap) pulses++;
    end
    chk("up12.final_count", 32'(count), SAT ? 32'd9 : 32'd2);
    chk("up12.pulses", 32'(pulses), SAT ? 32'd3 : 32'd1);
    chk("up12.ovf_set", 32'(ovf), 32'd1);
    chk("up12.unf_clear", 32'(unf), 32'd0);

    // down x2 from 0, then clear flags
    drive(1, 0, 0, 0, 4'd0, 0); cyc("rst2");
    drive(0, 1, 0, 0, 4'd0, 0); cyc("dn1");
    chk("dn1.count_lit", 32'(count), SAT ? 32'd0 : 32'd9);
    cyc("dn2");
    chk("dn2.count_lit", 32'(count), SAT ? 32'd0 : 32'd8);
    drive(0, 0, 0, 0, 4'd0, 1); cyc("clr");
    chk("clr.unf_lit", 32'(unf), 32'd0);

    // load clamp overrides en
    drive(0, 1, 1, 1, 4'd14, 0); cyc("load14");
    chk("load14.count_lit", 32'(count), 32'd9);
    chk("load14.wrap_lit", 32'(wrap), 32'd0);
    drive(0, 1, 0, 1, 4'd3, 0); cyc("load3");
    chk("load3.count_lit", 32'(count), 32'd3);

    // set beats clear on the same edge
    drive(0, 0, 0, 1, 4'd9, 0); cyc("load9");
    drive(0, 1, 1, 0, 4'd0, 1); cyc("set_wins");
    chk("set_wins.ovf_lit", 32'(ovf), 32'd1);

    // reset mid-count with a pending limit event
    drive(0, 0, 0, 1, 4'd5, 0); cyc("load5");
    drive(1, 1, 1, 0, 4'd0, 0); cyc("rst_mid");
    drive(0, 0, 1, 1, 4'd9, 0); cyc("load9b");
    drive(1, 1, 1, 0, 4'd0, 0); cyc("rst_at_limit");
    chk("rst_at_limit.wrap_lit", 32'(wrap), 32'd0);
    drive(0, 0, 1, 0, 4'd0, 0); cyc("post_rst");

    // back-to-back limit events at the top, then at the bottom
    drive(0, 0, 1, 1, 4'd9, 0); cyc("load9c");
    drive(0, 1, 1, 0, 4'd0, 0);
    for (int i = 0; i < 3; i++) cyc("top_x3");
    drive(0, 0, 0, 1, 4'd0, 0); cyc("load0");
    drive(0, 1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 3; i++) cyc("bot_x3");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 9) == 0), 4'($urandom), ($urandom_range(0, 7) == 0));
      cyc("rand");
      tests++;
      assert (int'(count) <= M) else begin
        fails++;
        $error("FAIL rand.range observed=%0d expected<=%0d", count, M);
      end
    end

    // 8-bit default MAX: 256 up steps from 0
    drive(0, 0, 0, 0, 4'd0, 0);
    rst8 = 1'b1;
    @(posedge clk); #1;
    chk("w8.reset_count", 32'(count8), 32'd0);
    chk("w8.reset_ovf", 32'(ovf8), 32'd0);
    rst8 = 1'b0; en8 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (wrap8) pulses++;
      if (i == 254) chk("w8.at_max", 32'(at_max8), 32'd1);
    end
    en8 = 1'b0;
    chk("w8.count", 32'(count8), SAT ? 32'd255 : 32'd0);
    chk("w8.pulses", 32'(pulses), 32'd1);
    chk("w8.ovf", 32'(ovf8), 32'd1);
    chk("w8.unf", 32'(unf8), 32'd0);
    @(posedge clk); #1;
    chk("w8.wrap_drop", 32'(wrap8), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
